// File: rtl/param_counter_if.sv
// ---------------------------------------------------------------------------
// param_counter_if
// Bundles the control/data signals of param_counter so that driver and
// monitor agents can share a single handle.
//   master : drives en, load, up_dn, data_in (and ovf_clr when the sticky
//            overflow option is built in); observes data_out, tc, wrap
//            (and ovf_sticky).
//   slave  : the counter itself, the mirror image of master.
// Optional feature macro: PARAM_COUNTER_OVF_STICKY_EN adds ovf_clr and
// ovf_sticky.
// ---------------------------------------------------------------------------
interface param_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             load;
  logic             up_dn;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             tc;
  logic             wrap;
`ifdef PARAM_COUNTER_OVF_STICKY_EN
  logic             ovf_clr;
  logic             ovf_sticky;
`endif

`ifdef PARAM_COUNTER_OVF_STICKY_EN
  modport master (
    output en, load, up_dn, data_in, ovf_clr,
    input  data_out, tc, wrap, ovf_sticky
  );
  modport slave (
    input  en, load, up_dn, data_in, ovf_clr,
    output data_out, tc, wrap, ovf_sticky
  );
`else
  modport master (
    output en, load, up_dn, data_in,
    input  data_out, tc, wrap
  );
  modport slave (
    input  en, load, up_dn, data_in,
    output data_out, tc, wrap
  );
`endif
endinterface

// File: rtl/param_counter.sv
// ---------------------------------------------------------------------------
// param_counter
// Loadable modulo-MODULO up/down counter with count enable, wrap or
// saturate behaviour at the range ends, a combinational terminal-count
// flag and a registered one-cycle wrap/saturate-hit pulse.
// Parameters:
//   WIDTH    : counter width in bits (>= 2)
//   MODULO   : count range 0..MODULO-1, 2..2**WIDTH
//   SATURATE : 0 = wrap at the range ends, 1 = hold at the range ends
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-low
//   bus  : param_counter_if.slave
//            en, load, up_dn, data_in  (in)
//            data_out, tc, wrap        (out)
//            ovf_clr (in), ovf_sticky (out) with PARAM_COUNTER_OVF_STICKY_EN
// Optional feature macro: PARAM_COUNTER_OVF_STICKY_EN (sticky overflow flag).
// Priority of updates: rst > load > en > hold.
// ---------------------------------------------------------------------------
module param_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULO   = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  param_counter_if.slave    bus
);

  // MAXV is held one bit wider so MODULO == 2**WIDTH never truncates.
  localparam logic [WIDTH:0]   MAXV_X = (WIDTH+1)'(MODULO - 1);
  localparam logic [WIDTH-1:0] MAXV   = MAXV_X[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             at_max, at_zero, boundary;
`ifdef PARAM_COUNTER_OVF_STICKY_EN
  logic             ovf_q, ovf_d;
`endif

  always_comb begin
    at_max   = (cnt_q == MAXV);
    at_zero  = (cnt_q == '0);
    boundary = bus.up_dn ? at_max : at_zero;

    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (bus.load) begin
      // Load values beyond the range clamp to MAXV; compared in WIDTH+1
      // bits so the clamp is a no-op when MODULO == 2**WIDTH.
      cnt_d = ({1'b0, bus.data_in} > MAXV_X) ? MAXV : bus.data_in;
    end else if (bus.en) begin
      wrap_d = boundary;
      // +/-1 only happens strictly inside the range, so WIDTH bits suffice.
      if (bus.up_dn) begin
        if (at_max) cnt_d = SATURATE ? MAXV : '0;
        else        cnt_d = cnt_q + ONE;
      end else begin
        if (at_zero) cnt_d = SATURATE ? '0 : MAXV;
        else         cnt_d = cnt_q - ONE;
      end
    end

`ifdef PARAM_COUNTER_OVF_STICKY_EN
    // A boundary event in the same cycle as a clear keeps the flag set.
    ovf_d = wrap_d | (ovf_q & ~bus.ovf_clr);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
`ifdef PARAM_COUNTER_OVF_STICKY_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
`ifdef PARAM_COUNTER_OVF_STICKY_EN
      ovf_q  <= ovf_d;
`endif
    end
  end

  assign bus.data_out = cnt_q;
  assign bus.wrap     = wrap_q;
  // Flags that the next enabled edge is a boundary event.
  assign bus.tc       = bus.en & boundary;
`ifdef PARAM_COUNTER_OVF_STICKY_EN
  assign bus.ovf_sticky = ovf_q;
`endif

endmodule

// File: tb/tb_param_counter.sv
// ---------------------------------------------------------------------------
// tb_param_counter
// Directed bench for param_counter. Three instances share one stimulus:
//   u0 : WIDTH=4, MODULO=10, SATURATE=0
//   u1 : WIDTH=4, MODULO=10, SATURATE=1
//   u2 : WIDTH=4, MODULO=16, SATURATE=0 (natural binary roll-over)
// Expected values are hand-computed per instance.
// ---------------------------------------------------------------------------
module tb_param_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, load, up_dn, ovf_clr;
  logic [3:0] data_in;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  param_counter_if #(.WIDTH(4)) bus0 ();
  param_counter_if #(.WIDTH(4)) bus1 ();
  param_counter_if #(.WIDTH(4)) bus2 ();

  assign bus0.en = en;  assign bus0.load = load;  assign bus0.up_dn = up_dn;  assign bus0.data_in = data_in;
  assign bus1.en = en;  assign bus1.load = load;  assign bus1.up_dn = up_dn;  assign bus1.data_in = data_in;
  assign bus2.en = en;  assign bus2.load = load;  assign bus2.up_dn = up_dn;  assign bus2.data_in = data_in;
`ifdef PARAM_COUNTER_OVF_STICKY_EN
  assign bus0.ovf_clr = ovf_clr;
  assign bus1.ovf_clr = ovf_clr;
  assign bus2.ovf_clr = ovf_clr;
`endif

  param_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1'b0)) u0 (.clk(clk), .rst(rst_n), .bus(bus0));
  param_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1'b1)) u1 (.clk(clk), .rst(rst_n), .bus(bus1));
  param_counter #(.WIDTH(4), .MODULO(16), .SATURATE(1'b0)) u2 (.clk(clk), .rst(rst_n), .bus(bus2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_d(input string tag, input int e0, input int e1, input int e2);
    check({tag, " d_out u0"}, 32'(bus0.data_out), e0);
    check({tag, " d_out u1"}, 32'(bus1.data_out), e1);
    check({tag, " d_out u2"}, 32'(bus2.data_out), e2);
  endtask

  task automatic exp_w(input string tag, input int e0, input int e1, input int e2);
    check({tag, " wrap u0"}, 32'(bus0.wrap), e0);
    check({tag, " wrap u1"}, 32'(bus1.wrap), e1);
    check({tag, " wrap u2"}, 32'(bus2.wrap), e2);
  endtask

  // tc is combinational: let the new inputs settle before sampling.
  task automatic exp_t(input string tag, input int e0, input int e1, input int e2);
    #1;
    check({tag, " tc u0"}, 32'(bus0.tc), e0);
    check({tag, " tc u1"}, 32'(bus1.tc), e1);
    check({tag, " tc u2"}, 32'(bus2.tc), e2);
  endtask

  task automatic drive(input logic r, input logic l, input logic e, input logic u, input int d);
    rst_n   = r;
    load    = l;
    en      = e;
    up_dn   = u;
    data_in = 4'(d);
  endtask

  initial begin
    ovf_clr = 1'b0;

    // Reset overrides a pending load
    drive(1'b0, 1'b1, 1'b0, 1'b1, 7);
    cyc(); cyc();
    exp_d("reset", 0, 0, 0);
    exp_w("reset", 0, 0, 0);
    exp_t("reset en0", 0, 0, 0);
`ifdef PARAM_COUNTER_OVF_STICKY_EN
    check("reset sticky u0", 32'(bus0.ovf_sticky), 0);
`endif

    drive(1'b1, 1'b1, 1'b0, 1'b1, 7);
    cyc();
    exp_d("load7", 7, 7, 7);

    // Count up across the top boundary
    drive(1'b1, 1'b1, 1'b0, 1'b1, 8);
    cyc();
    exp_d("load8", 8, 8, 8);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 0);
    exp_t("up at8", 0, 0, 0);
    cyc();
    exp_d("up1", 9, 9, 9);
    exp_w("up1", 0, 0, 0);
    exp_t("up at9", 1, 1, 0);
    cyc();
    exp_d("up2", 0, 9, 10);
    exp_w("up2", 1, 1, 0);
    exp_t("up2", 0, 1, 0);
    cyc();
    exp_d("up3", 1, 9, 11);
    exp_w("up3", 0, 1, 0);
`ifdef PARAM_COUNTER_OVF_STICKY_EN
    check("sticky set u0", 32'(bus0.ovf_sticky), 1);
    check("sticky idle u2", 32'(bus2.ovf_sticky), 0);
`endif

    // Hold with en low
    drive(1'b1, 1'b0, 1'b0, 1'b1, 0);
    exp_t("hold", 0, 0, 0);
    cyc();
    exp_d("hold", 1, 9, 11);
    exp_w("hold", 0, 0, 0);
`ifdef PARAM_COUNTER_OVF_STICKY_EN
    check("sticky held u0", 32'(bus0.ovf_sticky), 1);
`endif

    // Count down across zero
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1);
    cyc();
    exp_d("load1", 1, 1, 1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 0);
    exp_t("dn at1", 0, 0, 0);
    cyc();
    exp_d("dn1", 0, 0, 0);
    exp_w("dn1", 0, 0, 0);
    exp_t("dn at0", 1, 1, 1);
    cyc();
    exp_d("dn2", 9, 0, 15);
    exp_w("dn2", 1, 1, 1);
    cyc();
    exp_d("dn3", 8, 0, 14);
    exp_w("dn3", 0, 1, 0);

    // Saturate at the top, then reverse direction
    drive(1'b1, 1'b1, 1'b0, 1'b1, 9);
    cyc();
    exp_d("load9", 9, 9, 9);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 0);
    cyc();
    exp_d("sat1", 0, 9, 10);
    exp_w("sat1", 1, 1, 0);
    cyc();
    exp_d("sat2", 1, 9, 11);
    exp_w("sat2", 0, 1, 0);
    cyc();
    exp_d("sat3", 2, 9, 12);
    exp_w("sat3", 0, 1, 0);
    up_dn = 1'b0;
    cyc();
    exp_d("rev", 1, 8, 11);
    exp_w("rev", 0, 0, 0);

    // Load clamp and load-over-enable priority
    drive(1'b1, 1'b1, 1'b0, 1'b1, 13);
    cyc();
    exp_d("clamp", 9, 9, 13);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4);
    cyc();
    exp_d("load>en", 4, 4, 4);
    exp_w("load>en", 0, 0, 0);

    // Full-range roll-over on u2; load at boundary suppresses wrap
    drive(1'b1, 1'b1, 1'b1, 1'b1, 15);
    cyc();
    exp_d("load15", 9, 9, 15);
    exp_w("load15", 0, 0, 0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 0);
    cyc();
    exp_d("roll", 0, 9, 0);
    exp_w("roll", 1, 1, 1);

    // Reset mid-count
    drive(1'b0, 1'b0, 1'b1, 1'b1, 0);
    cyc();
    exp_d("rst mid", 0, 0, 0);
    exp_w("rst mid", 0, 0, 0);

`ifdef PARAM_COUNTER_OVF_STICKY_EN
    check("sticky rst u0", 32'(bus0.ovf_sticky), 0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 9);
    cyc();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 0);
    cyc();
    check("sticky wrap u0", 32'(bus0.ovf_sticky), 1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 9);
    cyc();
    check("sticky keep u0", 32'(bus0.ovf_sticky), 1);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 0);
    ovf_clr = 1'b1;
    cyc();
    check("sticky set>clr u0", 32'(bus0.ovf_sticky), 1);
    check("wrap with clr u0", 32'(bus0.wrap), 1);
    en = 1'b0;
    cyc();
    check("sticky clr u0", 32'(bus0.ovf_sticky), 0);
    check("sticky clr u1", 32'(bus1.ovf_sticky), 0);
    ovf_clr = 1'b0;
    cyc();
    check("sticky stays clr u0", 32'(bus0.ovf_sticky), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
